// File: rtl/alu_pkg.sv
// Shared encodings for the handshaked ALU: unit/op codes, FSM states and unit_flags bit positions.
package alu_pkg;

    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_NOR  = 2'b11;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_EQ   = 2'b01;
    localparam logic [1:0] OP_GT   = 2'b10;
    localparam logic [1:0] OP_LT   = 2'b11;

    localparam logic [1:0] OP_SHR_A = 2'b00;
    localparam logic [1:0] OP_SHL_A = 2'b01;
    localparam logic [1:0] OP_SHR_B = 2'b10;
    localparam logic [1:0] OP_SHL_B = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam int UF_ARITH = 0;
    localparam int UF_LOGIC = 1;
    localparam int UF_CMP   = 2;
    localparam int UF_SHIFT = 3;

    // Unit select code maps directly onto its unit_flags bit position.
    function automatic logic [3:0] unit_onehot(input logic [1:0] unit);
        return 4'b0001 << unit;
    endfunction

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring divider: one quotient bit per cycle, WIDTH cycles after start.
// quot/rem carry the result of the current step, so they are final in the cycle done is high.
module alu_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic             running;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   trial;

    // Shift the next dividend bit into the remainder and try subtracting the divisor.
    assign partial = {rem_q, quot_q[WIDTH-1]};
    assign trial   = partial - {1'b0, div_q};
    assign rem     = trial[WIDTH] ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quot    = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
    assign done    = running && (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            count   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            div_q   <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= '0;
            rem_q   <= '0;
            quot_q  <= a;
            div_q   <= b;
        end else if (running) begin
            rem_q  <= rem;
            quot_q <= quot;
            count  <= count + 1'b1;
            if (count == LAST) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe_hs.sv
// Handshaked ALU: one transaction in flight, result registered and held until out_ready.
// Non-divide ops complete in one cycle; valid divides run the iterative divider for WIDTH cycles.
module alu_pipe_hs
    import alu_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  bit DIV_EN = 1'b1,
    localparam int RES_W  = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_FUN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] alu_out,
    output logic [3:0]       unit_flags,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             err_flag,
    output logic             busy
);
    logic [1:0]       state;
    logic [1:0]       unit;
    logic [1:0]       op;
    logic             accept;
    logic             is_div;
    logic             div_go;
    logic             div_done;
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_rem;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [RES_W-1:0] prod;
    logic [WIDTH-1:0] res_lo;
    logic [RES_W-1:0] res_c;
    logic             carry_c;
    logic             err_c;

    assign unit      = ALU_FUN[3:2];
    assign op        = ALU_FUN[1:0];
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);
    assign in_ready  = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign is_div    = (unit == UNIT_ARITH) && (op == OP_DIV);
    assign div_go    = accept && is_div && DIV_EN && (B != '0);

    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = A - B;
    assign prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    generate
        if (DIV_EN) begin : g_div
            alu_divider #(.WIDTH(WIDTH)) u_div (
                .clk   (clk),
                .reset (reset),
                .start (div_go),
                .a     (A),
                .b     (B),
                .done  (div_done),
                .quot  (div_quot),
                .rem   (div_rem)
            );
        end else begin : g_no_div
            assign div_done = 1'b0;
            assign div_quot = '0;
            assign div_rem  = '0;
        end
    endgenerate

    // NOTE: every output of this block gets a default first, so no path through
    // the case statements can leave a value unassigned and infer a latch.
    always_comb begin
        res_lo  = '0;
        res_c   = '0;
        carry_c = 1'b0;
        err_c   = 1'b0;
        case (unit)
            UNIT_ARITH: begin
                case (op)
                    OP_ADD: begin
                        res_c   = {{(WIDTH - 1){1'b0}}, sum};
                        carry_c = sum[WIDTH];
                    end
                    OP_SUB: begin
                        res_c   = {{WIDTH{1'b0}}, diff};
                        carry_c = (A < B);
                    end
                    OP_MUL: res_c = prod;
                    default: begin
                        // Only the immediate divide outcomes are captured from here.
                        err_c = !DIV_EN || (B == '0);
                        if (DIV_EN && (B == '0)) begin
                            res_c = {A, {WIDTH{1'b1}}};
                        end
                    end
                endcase
            end
            UNIT_LOGIC: begin
                case (op)
                    OP_AND:  res_lo = A & B;
                    OP_OR:   res_lo = A | B;
                    OP_NAND: res_lo = ~(A & B);
                    default: res_lo = ~(A | B);
                endcase
                res_c = {{WIDTH{1'b0}}, res_lo};
            end
            UNIT_CMP: begin
                case (op)
                    OP_EQ:   res_lo = (A == B) ? WIDTH'(1) : '0;
                    OP_GT:   res_lo = (A > B)  ? WIDTH'(2) : '0;
                    OP_LT:   res_lo = (A < B)  ? WIDTH'(3) : '0;
                    default: res_lo = '0;
                endcase
                res_c = {{WIDTH{1'b0}}, res_lo};
            end
            default: begin
                case (op)
                    OP_SHR_A: res_lo = {1'b0, A[WIDTH-1:1]};
                    OP_SHL_A: res_lo = {A[WIDTH-2:0], 1'b0};
                    OP_SHR_B: res_lo = {1'b0, B[WIDTH-1:1]};
                    default:  res_lo = {B[WIDTH-2:0], 1'b0};
                endcase
                res_c = {{WIDTH{1'b0}}, res_lo};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            alu_out    <= '0;
            unit_flags <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
            err_flag   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        if (div_go) begin
                            state <= ST_DIV;
                        end else begin
                            state      <= ST_HOLD;
                            alu_out    <= res_c;
                            unit_flags <= unit_onehot(unit);
                            carry_flag <= carry_c;
                            zero_flag  <= (res_c[WIDTH-1:0] == '0);
                            err_flag   <= err_c;
                        end
                    end else if (state == ST_HOLD && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        state      <= ST_HOLD;
                        alu_out    <= {div_rem, div_quot};
                        unit_flags <= unit_onehot(UNIT_ARITH);
                        carry_flag <= 1'b0;
                        zero_flag  <= (div_quot == '0);
                        err_flag   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Scoreboard bench for alu_pipe_hs: stimulus pushes expected results, a monitor pops on each output handshake.
module tb_alu_pipe_hs;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [3:0]  uf;
        logic        c;
        logic        z;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] A, B;
    logic [3:0]  ALU_FUN;
    logic [31:0] alu_out;
    logic [3:0]  unit_flags;
    logic        carry_flag, zero_flag, err_flag, busy;

    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [31:0] alu_out1;
    logic [3:0]  unit_flags1;
    logic        carry_flag1, zero_flag1, err_flag1, busy1;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_pipe_hs #(.WIDTH(16), .DIV_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALU_FUN(ALU_FUN), .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .unit_flags(unit_flags), .carry_flag(carry_flag),
        .zero_flag(zero_flag), .err_flag(err_flag), .busy(busy)
    );

    alu_pipe_hs #(.WIDTH(16), .DIV_EN(1'b0)) dut_nodiv (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .A(A), .B(B), .ALU_FUN(ALU_FUN), .out_valid(out_valid1), .out_ready(out_ready1),
        .alu_out(alu_out1), .unit_flags(unit_flags1), .carry_flag(carry_flag1),
        .zero_flag(zero_flag1), .err_flag(err_flag1), .busy(busy1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present a request, wait (bounded) for acceptance, push its expected result, then scramble operands.
    task automatic send(input string name, input logic [3:0] fun, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] res, input logic [3:0] uf,
                        input logic c, input logic z, input logic e, output int waits);
        exp_t x;
        in_valid = 1'b1;
        ALU_FUN  = fun;
        A        = a;
        B        = b;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: request not accepted within 200 cycles", name);
        end else begin
            @(posedge clk);
            x.name = name; x.res = res; x.uf = uf; x.c = c; x.z = z; x.e = e;
            sb.push_back(x);
        end
        #1;
        in_valid = 1'b0;
        A        = 16'($urandom);
        B        = 16'($urandom);
        ALU_FUN  = 4'($urandom);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got 0x%0h, expected no output", alu_out);
                end else begin
                    x = sb.pop_front();
                    check({x.name, ".res"},   alu_out,    x.res);
                    check({x.name, ".flags"}, unit_flags, x.uf);
                    check({x.name, ".cze"},   {carry_flag, zero_flag, err_flag}, {x.c, x.z, x.e});
                end
            end
        end
    end

    initial begin : stimulus
        int w0, w1, w2, cnt;
        in_valid   = 1'b0;
        in_valid1  = 1'b0;
        out_ready  = 1'b1;
        out_ready1 = 1'b1;
        A = '0; B = '0; ALU_FUN = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("reset.out_valid", out_valid, 0);
        check("reset.in_ready", in_ready, 1);
        check("reset.busy", busy, 0);
        check("reset.alu_out", alu_out, 0);
        check("reset.unit_flags", unit_flags, 0);
        check("reset.cze", {carry_flag, zero_flag, err_flag}, 0);
        check("reset.nodiv_out_valid", out_valid1, 0);

        // Arithmetic
        send("add_carry", 4'b0000, 16'hFFFF, 16'h0001, 32'h0001_0000, 4'b0001, 1, 1, 0, w0);
        check("add_latency", out_valid, 1);
        send("add", 4'b0000, 16'h1234, 16'h4321, 32'h0000_5555, 4'b0001, 0, 0, 0, w0);
        send("sub_borrow", 4'b0001, 16'd3, 16'd5, 32'h0000_FFFE, 4'b0001, 1, 0, 0, w0);
        send("sub_zero", 4'b0001, 16'd5, 16'd5, 32'h0000_0000, 4'b0001, 0, 1, 0, w0);
        send("mul_max", 4'b0010, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 4'b0001, 0, 0, 0, w0);

        // Logic, compare, shift
        send("or",   4'b0101, 16'hF0F0, 16'h0FF0, 32'h0000_FFF0, 4'b0010, 0, 0, 0, w0);
        send("nand", 4'b0110, 16'hF0F0, 16'h0FF0, 32'h0000_FF0F, 4'b0010, 0, 0, 0, w0);
        send("nor",  4'b0111, 16'hF0F0, 16'h0FF0, 32'h0000_000F, 4'b0010, 0, 0, 0, w0);
        send("nop",  4'b1000, 16'd7, 16'd7, 32'd0, 4'b0100, 0, 1, 0, w0);
        send("eq_t", 4'b1001, 16'd7, 16'd7, 32'd1, 4'b0100, 0, 0, 0, w0);
        send("eq_f", 4'b1001, 16'd7, 16'd8, 32'd0, 4'b0100, 0, 1, 0, w0);
        send("gt_f", 4'b1010, 16'd3, 16'd5, 32'd0, 4'b0100, 0, 1, 0, w0);
        send("lt_t", 4'b1011, 16'd3, 16'd5, 32'd3, 4'b0100, 0, 0, 0, w0);
        send("lt_f", 4'b1011, 16'd5, 16'd3, 32'd0, 4'b0100, 0, 1, 0, w0);
        send("shr_a", 4'b1100, 16'h8001, 16'h0000, 32'h0000_4000, 4'b1000, 0, 0, 0, w0);
        send("shr_b", 4'b1110, 16'h0000, 16'h0003, 32'h0000_0001, 4'b1000, 0, 0, 0, w0);
        send("shl_b", 4'b1111, 16'h0000, 16'hC000, 32'h0000_8000, 4'b1000, 0, 0, 0, w0);

        // Back-to-back at full throughput
        send("b2b_and", 4'b0100, 16'hF0F0, 16'h0FF0, 32'h0000_00F0, 4'b0010, 0, 0, 0, w0);
        send("b2b_gt",  4'b1010, 16'd5, 16'd3, 32'd2, 4'b0100, 0, 0, 0, w1);
        send("b2b_shl", 4'b1101, 16'h8001, 16'h0000, 32'h0000_0002, 4'b1000, 0, 0, 0, w2);
        check("b2b_in_ready_waits", w0 + w1 + w2, 0);

        // Iterative divide: WIDTH busy cycles, then result
        send("div_100_7", 4'b0011, 16'd100, 16'd7, 32'h0002_000E, 4'b0001, 0, 0, 0, w0);
        check("div_busy_in_ready", {busy, in_ready}, 2'b10);
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            @(posedge clk);
            #1 cnt++;
        end
        check("div_latency_cycles", cnt, 16);
        send("div_max", 4'b0011, 16'hFFFF, 16'h0001, 32'h0000_FFFF, 4'b0001, 0, 0, 0, w0);
        send("div_small", 4'b0011, 16'd5, 16'd9, 32'h0005_0000, 4'b0001, 0, 1, 0, w0);
        send("div_by_zero", 4'b0011, 16'h1234, 16'h0000, 32'h1234_FFFF, 4'b0001, 0, 0, 1, w0);
        check("div_by_zero_latency", out_valid, 1);
        repeat (3) @(posedge clk);

        // Divide disabled: illegal op, latency 1
        #1;
        in_valid1 = 1'b1;
        ALU_FUN   = 4'b0011;
        A         = 16'h1234;
        B         = 16'h0005;
        @(negedge clk);
        check("nodiv.in_ready", in_ready1, 1);
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        check("nodiv.out_valid", out_valid1, 1);
        check("nodiv.res", alu_out1, 0);
        check("nodiv.flags", unit_flags1, 4'b0001);
        check("nodiv.cze", {carry_flag1, zero_flag1, err_flag1}, 3'b011);
        @(posedge clk);
        #1 check("nodiv.idle", {out_valid1, busy1}, 2'b00);

        // Backpressure: result held, next request stalls until out_ready
        out_ready = 1'b0;
        send("bp_mul", 4'b0010, 16'h0100, 16'h0100, 32'h0001_0000, 4'b0001, 0, 1, 0, w0);
        in_valid = 1'b1;
        ALU_FUN  = 4'b0000;
        A        = 16'd1;
        B        = 16'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {out_valid, in_ready, alu_out}, {1'b1, 1'b0, 32'h0001_0000});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send("bp_add", 4'b0000, 16'd1, 16'd1, 32'd2, 4'b0001, 0, 0, 0, w0);
        check("bp_release_waits", w0, 0);

        // Reset five cycles into a divide aborts it
        send("div_abort", 4'b0011, 16'd100, 16'd7, 32'h0002_000E, 4'b0001, 0, 0, 0, w0);
        void'(sb.pop_back());
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort_state", {out_valid, in_ready, busy}, 3'b010);
        send("post_abort_add", 4'b0000, 16'd2, 16'd3, 32'd5, 4'b0001, 0, 0, 0, w0);

        cnt = 0;
        while (sb.size() != 0 && cnt < 100) begin
            @(posedge clk);
            cnt++;
        end
        check("drain_queue", sb.size(), 0);
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
